// File: rtl/des_core.sv
// rtl/des_core.sv - iterative DES core, one Feistel round per clock, free-running
// Optional key byte parity flag enabled by DES_KEY_PARITY_EN.
module des_core (
    output logic [0:63] desOut,
    input  logic [0:63] desIn,
    input  logic [0:63] key,
    input  logic        decrypt,
    input  logic        clk,
    input  logic        rst_n,
    output logic        done
`ifdef DES_KEY_PARITY_EN
    ,
    output logic        key_parity_err
`endif
);

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                                12,13,14,15,16,17, 16,17,18,19,20,21,
                                20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box is 64 nibbles, row-major (row*16+col), first nibble in the top bits.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] v);
        for (int i = 0; i < 64; i++) ip_perm[63-i] = v[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] v);
        for (int i = 0; i < 64; i++) fp_perm[63-i] = v[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] v);
        for (int i = 0; i < 56; i++) pc1[55-i] = v[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] v);
        for (int i = 0; i < 48; i++) pc2[47-i] = v[56-PC2_T[i]];
    endfunction

    // Left moves bits toward the MSB (FIPS bit 1); right by 0 leaves the half unchanged.
    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] n,
                                          input logic right);
        logic [55:0] dbl;
        dbl = {v, v};
        rot28 = right ? dbl[27+int'(n) -: 28] : dbl[55-int'(n) -: 28];
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  x;
        logic [31:0]  s;
        logic [5:0]   six;
        logic [255:0] sb;
        int           idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            sb  = SBOX[j];
            idx = 32'({six[5], six[0], six[4:1]});
            s[31-4*j -: 4] = sb[255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) feistel[31-i] = s[32-P_T[i]];
    endfunction

    logic [4:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d, r_q, r_d, f_w;
    logic [27:0] c_q, c_d, d_q, d_d, c_rot, d_rot;
    logic        mode_q, mode_d, done_q, done_d;
    logic [63:0] out_q, out_d, ip_w;
    logic [55:0] cd_w;
    logic [1:0]  amt;

    assign ip_w = ip_perm(desIn);
    assign cd_w = pc1(key);

    always_comb begin
        rnd_d  = rnd_q;
        l_d    = l_q;
        r_d    = r_q;
        c_d    = c_q;
        d_d    = d_q;
        mode_d = mode_q;
        out_d  = out_q;
        done_d = 1'b0;
        if (rnd_q == 5'd1 || rnd_q == 5'd2 || rnd_q == 5'd9 || rnd_q == 5'd16)
            amt = (mode_q && rnd_q == 5'd1) ? 2'd0 : 2'd1;
        else
            amt = 2'd2;
        c_rot = rot28(c_q, amt, mode_q);
        d_rot = rot28(d_q, amt, mode_q);
        f_w   = feistel(r_q, pc2({c_rot, d_rot}));
        if (rnd_q == 5'd0) begin
            l_d    = ip_w[63:32];
            r_d    = ip_w[31:0];
            c_d    = cd_w[55:28];
            d_d    = cd_w[27:0];
            mode_d = decrypt;
            rnd_d  = 5'd1;
        end else begin
            l_d = r_q;
            r_d = l_q ^ f_w;
            c_d = c_rot;
            d_d = d_rot;
            if (rnd_q == 5'd16) begin
                out_d  = fp_perm({l_q ^ f_w, r_q});
                done_d = 1'b1;
                rnd_d  = 5'd0;
            end else begin
                rnd_d = rnd_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd_q  <= 5'd0;
            l_q    <= 32'h0;
            r_q    <= 32'h0;
            c_q    <= 28'h0;
            d_q    <= 28'h0;
            mode_q <= 1'b0;
            out_q  <= 64'h0;
            done_q <= 1'b0;
        end else begin
            rnd_q  <= rnd_d;
            l_q    <= l_d;
            r_q    <= r_d;
            c_q    <= c_d;
            d_q    <= d_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign desOut = out_q;
    assign done   = done_q;

`ifdef DES_KEY_PARITY_EN
    logic par_q, par_d;

    // Every DES key byte must carry odd parity.
    always_comb begin
        par_d = par_q;
        if (rnd_q == 5'd0) begin
            par_d = 1'b0;
            for (int b = 0; b < 8; b++) if (~^key[8*b +: 8]) par_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign key_parity_err = par_q;
`endif

endmodule

// File: tb/tb_des_core.sv
// tb/tb_des_core.sv - self-checking bench for des_core (known vectors, random vs model)
module tb_des_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] des_in, key, des_out;
    logic        dec, done;
`ifdef DES_KEY_PARITY_EN
    logic        kpe;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_core dut (
        .desOut(des_out), .desIn(des_in), .key(key), .decrypt(dec),
        .clk(clk), .rst_n(rst_n), .done(done)
`ifdef DES_KEY_PARITY_EN
        , .key_parity_err(kpe)
`endif
    );

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Textbook DES: full subkey list up front, reversed for decryption, FP as inverse of IP.
    function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [63:0] k,
                                            input logic decr);
        logic [27:0]  c, d;
        logic [55:0]  cd;
        logic [47:0]  ks [16];
        logic [47:0]  e, rk;
        logic [63:0]  ip, pre, res;
        logic [31:0]  l, r, t, s, f;
        logic [5:0]   six;
        logic [255:0] sbx;
        int           row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < SHIFTS[n]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            rk = decr ? ks[15-n] : ks[n];
            for (int g = 0; g < 8; g++)
                for (int j = 0; j < 6; j++)
                    e[47-(6*g+j)] = r[31-((4*g+j+31) % 32)];
            e = e ^ rk;
            for (int g = 0; g < 8; g++) begin
                six = e[47-6*g -: 6];
                row = 2*int'(six[5]) + int'(six[0]);
                col = int'(six[4:1]);
                sbx = SB[g];
                s[31-4*g -: 4] = sbx[255-4*(row*16+col) -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[64-IP_T[i]] = pre[63-i];
        return res;
    endfunction

    typedef struct {
        logic [63:0] k;
        logic [63:0] din;
        logic        decr;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d cycles required=done", n);
        end
    endtask

    task automatic set_in(input logic [63:0] k, input logic [63:0] din, input logic decr);
        key    = k;
        des_in = din;
        dec    = decr;
    endtask

    initial begin
        int          n;
        logic [63:0] held, ra, rb;
        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

        rst_n = 1'b0;
        set_in(vecs[0].k, vecs[0].din, vecs[0].decr);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        check("reset_desOut", des_out, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            set_in(vecs[i].k, vecs[i].din, vecs[i].decr);
            wait_done(n);
            check($sformatf("vec%0d_latency", i), 64'(n), 64'd17);
            check($sformatf("vec%0d_desOut", i), des_out, vecs[i].exp);
            check($sformatf("vec%0d_model", i), ref_des(vecs[i].din, vecs[i].k, vecs[i].decr), vecs[i].exp);
        end

        held = des_out;
        step();
        check("done_pulse_width", {63'h0, done}, 64'h0);
        check("desOut_hold", des_out, held);
        wait_done(n);
        check("repeat_period", 64'(n), 64'd16);
        check("repeat_value", des_out, vecs[3].exp);

        for (int i = 0; i < 16; i++) begin
            set_in({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_done(n);
            check($sformatf("rand%0d_latency", i), 64'(n), 64'd17);
            check($sformatf("rand%0d_desOut", i), des_out, ref_des(des_in, key, dec));
        end

        set_in({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        ra = ref_des(des_in, key, dec);
        for (int i = 0; i < 7; i++) step();
        des_in = ~des_in;
        dec    = 1'b1;
        rb = ref_des(des_in, key, dec);
        wait_done(n);
        check("midchange_latency", 64'(n), 64'd10);
        check("midchange_old_value", des_out, ra);
        wait_done(n);
        check("midchange_new_value", des_out, rb);

        set_in(vecs[2].k, vecs[2].din, vecs[2].decr);
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        step();
        check("midreset_desOut", des_out, 64'h0);
        check("midreset_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        wait_done(n);
        check("postreset_latency", 64'(n), 64'd17);
        check("postreset_desOut", des_out, vecs[2].exp);

`ifdef DES_KEY_PARITY_EN
        set_in(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        step();
        check("parity_good_key", {63'h0, kpe}, 64'h0);
        wait_done(n);
        set_in(64'h0, 64'h0123456789ABCDEF, 1'b0);
        step();
        check("parity_zero_key", {63'h0, kpe}, 64'h1);
        wait_done(n);
        check("parity_zero_key_cipher", des_out, ref_des(des_in, key, dec));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_core.md
# des_core

Iterative DES (FIPS 46-3) block cipher core: encrypts or decrypts one 64-bit block with a 64-bit key, one Feistel round per clock. It runs free-running, with no start handshake. It repeatedly samples its inputs, computes 16 rounds, and updates a registered result. It sits as a leaf datapath block behind whatever register or bus logic supplies data and key.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low; one clock; sampled on `clk` rising edge.
- `desOut` out [0:63]: result block; bit 0 = FIPS bit 1 (MSB); registered.
- `desIn` in [0:63]: plaintext (encrypt) or ciphertext (decrypt); bit 0 = MSB.
- `key` in [0:63]: DES key including parity bits 7,15,...,63; parity bits ignored by the datapath.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt; sampled with the block.
- `done` out 1: one-cycle pulse when `desOut` has just been updated.
- `key_parity_err` out 1: present only with `DES_KEY_PARITY_EN` (see Configuration).
- Port order: `desOut, desIn, key, decrypt, clk, rst_n, done` (+ `key_parity_err`).

## Operation
- State:
  - 5-bit round counter `rnd` (0..16).
  - L, R: 32 bits each.
  - C, D: 28 bits each.
  - latched mode bit.
  - `desOut`, `done`.
- **Load** (`rnd`=0):
  - L‖R ← IP(`desIn`).
  - C‖D ← PC-1(`key`).
  - mode ← `decrypt`.
  - `rnd` ← 1.
- **Round i** (`rnd`=i, 1..16): key-schedule rotation, then Feistel step.
- Key rotation, encrypt: rotate C and D left by 1 for i ∈ {1,2,9,16}, else by 2, before forming Ki = PC-2(C‖D).
- Key rotation, decrypt: rotate C and D right by 0 for i=1, by 1 for i ∈ {2,9,16}, else by 2. This yields K16..K1 in order.
- Feistel step: L ← R; R ← L ⊕ P(S(E(R) ⊕ Ki)).
  - S-box j uses 6-bit group j with row = outer bits and column = inner 4 bits, per FIPS S1..S8.
- At i=16: `desOut` ← FP(R16‖L16), i.e. the halves are swapped before FP. Also `done` ← 1 and `rnd` ← 0.
- Inputs are ignored except in the load cycle; changes mid-block do not affect the block in flight.
- Encrypt and decrypt share one datapath; only the rotation direction differs.
- Reset (`rst_n`=0 at an edge): `rnd`=0, L=R=C=D=0, `desOut`=64'h0, `done`=0, mode=0. Any block in flight is discarded. Reset has priority over all other activity.

## Timing
- Block period: 17 cycles (1 load + 16 rounds), repeating indefinitely.
- Edge 1 (first edge with `rst_n`=1): load.
- Edges 2–17: rounds 1–16.
- Edge 17 also writes `desOut` and sets `done`=1.
- `done` is high exactly from edge 17 to edge 18.
- Edge 18: loads the next block. `desOut` holds its value until edge 34.
- Latency: input sampled at edge n produces its result at edge n+16.
- `desOut` changes only on `done` edges or reset.
- No combinational path from inputs to outputs.

## Configuration
- `DES_KEY_PARITY_EN` defined:
  - adds output `key_parity_err`.
  - Registered at the load edge: 1 if any key byte has even parity (each DES key byte must have odd parity), else 0.
  - Reset value 0.
  - Does not alter cipher output.
- Not defined: no port and no logic.

## Test plan
- Encrypt: `desIn`=0123456789ABCDEF, `key`=133457799BBCDFF1, `decrypt`=0. Required: `desOut`=85E813540F0AB405 at edge 17, `done` pulses for exactly one cycle, and the same value is repeated every 17 cycles.
- Decrypt: `desIn`=85E813540F0AB405, same key, `decrypt`=1. Required: `desOut`=0123456789ABCDEF.
- Second vector: `key`=0E329232EA6D0D73, `desIn`=8787878787878787, encrypt. Required: `desOut`=0000000000000000. With `decrypt`=1 on that output, the result must be 8787878787878787.
- Input change mid-block: change `desIn` at edge 8. Required: the current block still gives the value for the old input; the new input appears one block later.
- Reset mid-block: assert `rst_n`=0 at edge 10 for 1 cycle. Required: `desOut`=0 and `done`=0. After release, the first result arrives 17 edges later.
- `DES_KEY_PARITY_EN`: key 133457799BBCDFF1 → `key_parity_err`=0; key 0000000000000000 → `key_parity_err`=1.
